// File: rtl/nf10_rx_frame_buffer.sv
// nf10_rx_frame_buffer: packs the MAC byte stream into AXI4-Stream words
// through a store-and-forward buffer with per-frame commit and rewind.
module nf10_rx_frame_buffer #(
  parameter int C_M_AXIS_DATA_WIDTH = 64,
  parameter int C_BUFFER_DEPTH_LOG2 = 9
) (
  input  logic                               axi_aclk,
  input  logic                               axi_resetn,
  input  logic [7:0]                         rx_data,
  input  logic                               rx_data_valid,
  input  logic                               rx_good_frame,
  input  logic                               rx_bad_frame,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]   m_axis_tstrb,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  output logic                               m_axis_tlast,
  output logic [31:0]                        rx_pkt_count,
  output logic [31:0]                        rx_drop_count,
  output logic                               overflow
);
  localparam int W  = C_M_AXIS_DATA_WIDTH;
  localparam int N  = W / 8;
  localparam int FW = $clog2(N + 1);
  localparam int AW = C_BUFFER_DEPTH_LOG2;
  localparam int EW = 1 + N + W;
  localparam logic [AW:0]   FULL_X = {1'b1, {AW{1'b0}}};
  localparam logic [FW-1:0] FILL_N = FW'(N);

  logic [EW-1:0] mem [2**AW];

  logic [W-1:0]  stage_q, stage_d, stage_n;
  logic [FW-1:0] fill_q, fill_d, fill_n;
  logic          drop_q, drop_d, drop_n;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   commit_q, commit_d;
  logic [AW:0]   rd_ptr_q;
  logic          fin_v_q, fin_v_d;
  logic          fin_good_q, fin_good_d;
  logic          fin_bad_q, fin_bad_d;
  logic          fin_drop_q, fin_drop_d;
  logic [W-1:0]  fin_data_q, fin_data_d;
  logic [FW-1:0] fin_fill_q, fin_fill_d;
  logic [31:0]   pkt_q, pkt_d, dcnt_q, dcnt_d;
  logic          ovf_q, ovf_d;
  logic          we;
  logic [EW-1:0] wdata;
  logic          full;
  logic          ld;
  logic [W-1:0]  tdata_q;
  logic [N-1:0]  tstrb_q;
  logic          tlast_q, tvalid_q;

  function automatic logic [N-1:0] strb_of(input logic [FW-1:0] f);
    logic [N-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) s[i] = (FW'(i) < f);
    return s;
  endfunction

  assign full = ((wr_ptr_q ^ rd_ptr_q) == FULL_X);

  always_comb begin
    stage_n    = stage_q;
    fill_n     = fill_q;
    drop_n     = drop_q;
    stage_d    = stage_q;
    fill_d     = fill_q;
    drop_d     = drop_q;
    wr_ptr_d   = wr_ptr_q;
    commit_d   = commit_q;
    fin_v_d    = 1'b0;
    fin_good_d = fin_good_q;
    fin_bad_d  = fin_bad_q;
    fin_drop_d = fin_drop_q;
    fin_data_d = fin_data_q;
    fin_fill_d = fin_fill_q;
    pkt_d      = pkt_q;
    dcnt_d     = dcnt_q;
    ovf_d      = 1'b0;
    we         = 1'b0;
    wdata      = '0;
    // A full staging word is pushed only once the next byte shows up
    if (rx_data_valid && !drop_q) begin
      if (fill_q == FILL_N) begin
        if (full) begin
          drop_n = 1'b1;
        end else begin
          we       = 1'b1;
          wdata    = {1'b0, {N{1'b1}}, stage_q};
          wr_ptr_d = wr_ptr_q + 1'b1;
        end
        stage_n       = '0;
        stage_n[7:0]  = rx_data;
        fill_n        = FW'(1);
      end else begin
        if (fill_q == '0) stage_n = '0;
        for (int i = 0; i < N; i++)
          if (fill_q == FW'(i)) stage_n[i*8 +: 8] = rx_data;
        fill_n = fill_q + FW'(1);
      end
    end
    // Frame end is settled one cycle later, when no word push can collide
    if (rx_good_frame || rx_bad_frame) begin
      fin_v_d    = 1'b1;
      fin_good_d = rx_good_frame;
      fin_bad_d  = rx_bad_frame;
      fin_drop_d = drop_n;
      fin_data_d = stage_n;
      fin_fill_d = fill_n;
      stage_d    = '0;
      fill_d     = '0;
      drop_d     = 1'b0;
    end else begin
      stage_d = stage_n;
      fill_d  = fill_n;
      drop_d  = drop_n;
    end
    if (fin_v_q) begin
      if (fin_drop_q ||
          (fin_good_q && !fin_bad_q && fin_fill_q != '0 && full)) begin
        wr_ptr_d = commit_q;
        dcnt_d   = dcnt_q + 32'd1;
        ovf_d    = 1'b1;
      end else if (fin_bad_q) begin
        wr_ptr_d = commit_q;
        dcnt_d   = dcnt_q + 32'd1;
      end else if (fin_good_q && fin_fill_q != '0) begin
        we       = 1'b1;
        wdata    = {1'b1, strb_of(fin_fill_q), fin_data_q};
        wr_ptr_d = wr_ptr_q + 1'b1;
        commit_d = wr_ptr_q + 1'b1;
        pkt_d    = pkt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (we) mem[wr_ptr_q[AW-1:0]] <= wdata;
  end

  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn) begin
      stage_q    <= '0;
      fill_q     <= '0;
      drop_q     <= 1'b0;
      wr_ptr_q   <= '0;
      commit_q   <= '0;
      fin_v_q    <= 1'b0;
      fin_good_q <= 1'b0;
      fin_bad_q  <= 1'b0;
      fin_drop_q <= 1'b0;
      fin_data_q <= '0;
      fin_fill_q <= '0;
      pkt_q      <= '0;
      dcnt_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      stage_q    <= stage_d;
      fill_q     <= fill_d;
      drop_q     <= drop_d;
      wr_ptr_q   <= wr_ptr_d;
      commit_q   <= commit_d;
      fin_v_q    <= fin_v_d;
      fin_good_q <= fin_good_d;
      fin_bad_q  <= fin_bad_d;
      fin_drop_q <= fin_drop_d;
      fin_data_q <= fin_data_d;
      fin_fill_q <= fin_fill_d;
      pkt_q      <= pkt_d;
      dcnt_q     <= dcnt_d;
      ovf_q      <= ovf_d;
    end
  end

  // Output register is the FWFT stage; rd_ptr points at the next word to fetch
  assign ld = (!tvalid_q || m_axis_tready) && (rd_ptr_q != commit_q);

  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn) begin
      rd_ptr_q <= '0;
      tdata_q  <= '0;
      tstrb_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
    end else if (ld) begin
      {tlast_q, tstrb_q, tdata_q} <= mem[rd_ptr_q[AW-1:0]];
      tvalid_q <= 1'b1;
      rd_ptr_q <= rd_ptr_q + 1'b1;
    end else if (m_axis_tready) begin
      tvalid_q <= 1'b0;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tstrb  = tstrb_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tvalid = tvalid_q;
  assign rx_pkt_count  = pkt_q;
  assign rx_drop_count = dcnt_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_nf10_rx_frame_buffer.sv
// tb_nf10_rx_frame_buffer: scoreboard bench with a byte-level frame model,
// one 64-bit shallow instance and one 32-bit deep instance.
module tb_nf10_rx_frame_buffer;

  typedef struct packed {
    logic [127:0] data;
    logic [15:0]  strb;
    logic         last;
  } beat_t;

  logic clk = 1'b0;
  initial forever #5 clk = ~clk;

  logic        a_rstn, b_rstn;
  logic [7:0]  a_rx_data, b_rx_data;
  logic        a_rx_v, a_good, a_bad, b_rx_v, b_good, b_bad;
  logic [63:0] a_tdata;
  logic [7:0]  a_tstrb;
  logic        a_tvalid, a_tready, a_tlast, a_ovf;
  logic [31:0] a_pkt, a_drop;
  logic [31:0] b_tdata;
  logic [3:0]  b_tstrb;
  logic        b_tvalid, b_tready, b_tlast, b_ovf;
  logic [31:0] b_pkt, b_drop;
  logic        b_rand = 1'b0;

  nf10_rx_frame_buffer #(
    .C_M_AXIS_DATA_WIDTH(64),
    .C_BUFFER_DEPTH_LOG2(4)
  ) dut_a (
    .axi_aclk(clk), .axi_resetn(a_rstn),
    .rx_data(a_rx_data), .rx_data_valid(a_rx_v),
    .rx_good_frame(a_good), .rx_bad_frame(a_bad),
    .m_axis_tdata(a_tdata), .m_axis_tstrb(a_tstrb),
    .m_axis_tvalid(a_tvalid), .m_axis_tready(a_tready),
    .m_axis_tlast(a_tlast), .rx_pkt_count(a_pkt),
    .rx_drop_count(a_drop), .overflow(a_ovf)
  );

  nf10_rx_frame_buffer #(
    .C_M_AXIS_DATA_WIDTH(32),
    .C_BUFFER_DEPTH_LOG2(9)
  ) dut_b (
    .axi_aclk(clk), .axi_resetn(b_rstn),
    .rx_data(b_rx_data), .rx_data_valid(b_rx_v),
    .rx_good_frame(b_good), .rx_bad_frame(b_bad),
    .m_axis_tdata(b_tdata), .m_axis_tstrb(b_tstrb),
    .m_axis_tvalid(b_tvalid), .m_axis_tready(b_tready),
    .m_axis_tlast(b_tlast), .rx_pkt_count(b_pkt),
    .rx_drop_count(b_drop), .overflow(b_ovf)
  );

  beat_t qa[$];
  beat_t qb[$];
  int total = 0;
  int bad = 0;
  int pkt_exp[2];
  int drop_exp[2];
  int ovf_exp[2];
  int ovf_seen[2];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int qsize(input int w);
    return (w == 0) ? qa.size() : qb.size();
  endfunction

  task automatic check_beat(input int w, input logic [127:0] d,
                            input logic [15:0] s, input logic l);
    beat_t e;
    logic [127:0] m;
    if (qsize(w) == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_beat dut%0d: got %0h expected none", w, d);
    end else begin
      if (w == 0) e = qa.pop_front();
      else e = qb.pop_front();
      m = '0;
      for (int i = 0; i < 16; i++) if (e.strb[i]) m[i*8 +: 8] = 8'hFF;
      chk($sformatf("tdata_dut%0d", w), d & m, e.data & m);
      chk($sformatf("tstrb_dut%0d", w), 128'(s), 128'(e.strb));
      chk($sformatf("tlast_dut%0d", w), 128'(l), 128'(e.last));
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (a_rstn && a_tvalid && a_tready)
      check_beat(0, 128'(a_tdata), 16'(a_tstrb), a_tlast);
    if (b_rstn && b_tvalid && b_tready)
      check_beat(1, 128'(b_tdata), 16'(b_tstrb), b_tlast);
    if (a_rstn && a_ovf) ovf_seen[0]++;
    if (b_rstn && b_ovf) ovf_seen[1]++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (b_rand) b_tready = 1'($urandom_range(0, 1));
  end

  // Reference model: a good frame becomes ceil(len/N) little-endian beats
  task automatic push_exp(input int w, input int n, input byte unsigned by[$]);
    beat_t e;
    for (int k = 0; k < by.size(); k += n) begin
      e = '0;
      for (int j = 0; j < n && k + j < by.size(); j++) begin
        e.data[j*8 +: 8] = by[k+j];
        e.strb[j] = 1'b1;
      end
      e.last = (k + n >= by.size());
      if (w == 0) qa.push_back(e);
      else qb.push_back(e);
    end
  endtask

  task automatic drv(input int w, input logic [7:0] d, input logic v,
                     input logic g, input logic bb);
    @(posedge clk);
    #1;
    if (w == 0) begin
      a_rx_data = d; a_rx_v = v; a_good = g; a_bad = bb;
    end else begin
      b_rx_data = d; b_rx_v = v; b_good = g; b_bad = bb;
    end
  endtask

  task automatic send(input int w, input int len, input bit rnd,
                      input bit g, input bit bb, input bit ovf,
                      input bit co);
    byte unsigned by[$];
    bit lst;
    for (int i = 0; i < len; i++)
      by.push_back(rnd ? 8'($urandom) : 8'(i + 1));
    if (ovf) begin
      drop_exp[w]++;
      ovf_exp[w]++;
    end else if (bb) begin
      drop_exp[w]++;
    end else if (g && len > 0) begin
      push_exp(w, (w == 0) ? 8 : 4, by);
      pkt_exp[w]++;
    end
    for (int i = 0; i < len; i++) begin
      lst = (i == len - 1);
      drv(w, by[i], 1'b1, co && lst && g, co && lst && bb);
    end
    if (!co || len == 0) drv(w, 8'h00, 1'b0, g, bb);
    drv(w, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain(input int w, input int budget);
    int c;
    c = 0;
    while (qsize(w) != 0 && c < budget) begin
      @(posedge clk);
      c++;
    end
    total++;
    if (qsize(w) != 0) begin
      bad++;
      $display("FAIL drain_dut%0d: %0d beats outstanding, required 0",
               w, qsize(w));
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic chk_cnt(input int w);
    if (w == 0) begin
      chk("pkt_count_a", 128'(a_pkt), 128'(pkt_exp[0]));
      chk("drop_count_a", 128'(a_drop), 128'(drop_exp[0]));
    end else begin
      chk("pkt_count_b", 128'(b_pkt), 128'(pkt_exp[1]));
      chk("drop_count_b", 128'(b_drop), 128'(drop_exp[1]));
    end
    chk($sformatf("overflow_pulses_dut%0d", w),
        128'(ovf_seen[w]), 128'(ovf_exp[w]));
  endtask

  task automatic chk_zero(input int w);
    if (w == 0) begin
      chk("rst_tvalid_a", 128'(a_tvalid), 128'(0));
      chk("rst_tlast_a", 128'(a_tlast), 128'(0));
      chk("rst_tdata_a", 128'(a_tdata), 128'(0));
      chk("rst_tstrb_a", 128'(a_tstrb), 128'(0));
      chk("rst_pkt_a", 128'(a_pkt), 128'(0));
      chk("rst_drop_a", 128'(a_drop), 128'(0));
      chk("rst_ovf_a", 128'(a_ovf), 128'(0));
    end else begin
      chk("rst_tvalid_b", 128'(b_tvalid), 128'(0));
      chk("rst_tlast_b", 128'(b_tlast), 128'(0));
      chk("rst_tdata_b", 128'(b_tdata), 128'(0));
      chk("rst_tstrb_b", 128'(b_tstrb), 128'(0));
      chk("rst_pkt_b", 128'(b_pkt), 128'(0));
      chk("rst_drop_b", 128'(b_drop), 128'(0));
      chk("rst_ovf_b", 128'(b_ovf), 128'(0));
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    a_rstn = 1'b0; b_rstn = 1'b0;
    a_rx_data = '0; a_rx_v = 1'b0; a_good = 1'b0; a_bad = 1'b0;
    b_rx_data = '0; b_rx_v = 1'b0; b_good = 1'b0; b_bad = 1'b0;
    a_tready = 1'b0; b_tready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pkt_exp[i] = 0; drop_exp[i] = 0; ovf_exp[i] = 0; ovf_seen[i] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero(0);
    chk_zero(1);
    @(posedge clk);
    #1;
    a_rstn = 1'b1; b_rstn = 1'b1; a_tready = 1'b1;

    send(0, 13, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drain(0, 50);
    chk_cnt(0);
    send(0, 8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drain(0, 50);
    send(0, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    c = 0;
    while (!a_tvalid && c < 3) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("first_beat_latency", 128'(a_tvalid), 128'(1));
    drain(0, 50);
    send(0, 20, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    send(0, 10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drain(0, 50);
    chk_cnt(0);
    send(0, 30, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    send(0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    send(0, 11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    drain(0, 50);
    chk_cnt(0);

    a_tready = 1'b0;
    send(0, 64, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    send(0, 100, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    chk_cnt(0);
    #1;
    a_tready = 1'b1;
    drain(0, 100);
    chk_cnt(0);

    b_rand = 1'b1;
    for (int f = 0; f < 50; f++) begin
      send(1, $urandom_range(1, 1518), 1'b1, 1'b1, 1'b0, 1'b0,
           1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    drain(1, 20000);
    b_rand = 1'b0;
    @(posedge clk);
    #1;
    b_tready = 1'b0;
    chk_cnt(1);

    send(1, 12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    chk("held_tvalid_b", 128'(b_tvalid), 128'(1));
    for (int i = 0; i < 40; i++) drv(1, 8'($urandom), 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    b_rstn = 1'b0;
    b_rx_v = 1'b0;
    qb.delete();
    pkt_exp[1] = 0; drop_exp[1] = 0; ovf_exp[1] = 0; ovf_seen[1] = 0;
    @(posedge clk);
    @(negedge clk);
    chk_zero(1);
    @(posedge clk);
    #1;
    b_rstn = 1'b1;
    b_tready = 1'b1;
    send(1, 50, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drain(1, 100);
    chk_cnt(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
